// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the SYS_TOP command controller: command codes,
// register file map and FSM state encodings.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR     = 8'hAA;
  localparam logic [7:0] CMD_RF_RD     = 8'hBB;
  localparam logic [7:0] CMD_ALU_W_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_W_NOP = 8'hDD;

  localparam int unsigned RF_ADDR_OPA       = 0;
  localparam int unsigned RF_ADDR_OPB       = 1;
  localparam int unsigned RF_ADDR_UART_CFG  = 2;
  localparam int unsigned RF_ADDR_DIV_RATIO = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RF_WR_ADDR,
    ST_RF_WR_DATA,
    ST_RF_RD_ADDR,
    ST_RF_RD_WAIT,
    ST_ALU_OPA,
    ST_ALU_OPB,
    ST_ALU_FUN,
    ST_ALU_WAIT,
    ST_TX_LO,
    ST_TX_HI
  } ctrl_state_e;

  typedef enum logic [1:0] {
    PS_IDLE,
    PS_LO,
    PS_HI
  } push_state_e;

endpackage

// File: rtl/sys_cmd_ctrl_tx_push.sv
// TX FIFO pusher: writes the low byte, then optionally the high byte, of a
// word, one registered push per cycle, stalling while the FIFO is full.
module ctrl_tx_push
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    two_byte,
  input  logic [2*DATA_WIDTH-1:0] word,
  input  logic                    tx_full,
  output logic [DATA_WIDTH-1:0]   tx_wr_data,
  output logic                    tx_wr_inc,
  output logic                    hi_pend,
  output logic                    done
);

  push_state_e             st, st_nxt;
  logic [2*DATA_WIDTH-1:0] word_q, word_eff;
  logic                    two_q, two_eff, lo_pend;
  logic [DATA_WIDTH-1:0]   data_nxt;
  logic                    inc_nxt, done_nxt;

  // The start cycle is treated as a pending low byte so the first push
  // lands directly after the capture edge.
  assign word_eff = start ? word : word_q;
  assign two_eff  = start ? two_byte : two_q;
  assign lo_pend  = start || (st == PS_LO);
  assign hi_pend  = (st == PS_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= PS_IDLE;
      word_q     <= '0;
      two_q      <= 1'b0;
      tx_wr_data <= '0;
      tx_wr_inc  <= 1'b0;
      done       <= 1'b0;
    end else begin
      st         <= st_nxt;
      word_q     <= word_eff;
      two_q      <= two_eff;
      tx_wr_data <= data_nxt;
      tx_wr_inc  <= inc_nxt;
      done       <= done_nxt;
    end
  end

  always_comb begin
    st_nxt = st;
    if (lo_pend) begin
      if (tx_full) st_nxt = PS_LO;
      else         st_nxt = two_eff ? PS_HI : PS_IDLE;
    end else if (st == PS_HI && !tx_full) begin
      st_nxt = PS_IDLE;
    end
  end

  always_comb begin
    data_nxt = tx_wr_data;
    inc_nxt  = 1'b0;
    done_nxt = 1'b0;
    if (lo_pend) begin
      data_nxt = word_eff[DATA_WIDTH-1:0];
      inc_nxt  = !tx_full;
      done_nxt = !tx_full && !two_eff;
    end else if (st == PS_HI) begin
      data_nxt = word_q[2*DATA_WIDTH-1:DATA_WIDTH];
      inc_nxt  = !tx_full;
      done_nxt = !tx_full;
    end
  end

endmodule

// File: rtl/sys_cmd_ctrl.sv
// Command sequencer: decodes host frames from UART RX, drives register file
// and ALU, and returns response bytes through the TX FIFO.
module sys_cmd_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_OUT_WIDTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  output logic                     RF_WrEn,
  output logic                     RF_RdEn,
  output logic [ADDR_WIDTH-1:0]    RF_Address,
  output logic [DATA_WIDTH-1:0]    RF_WrData,
  input  logic [DATA_WIDTH-1:0]    RF_RdData,
  input  logic                     RF_RdData_VLD,
  output logic                     ALU_EN,
  output logic [3:0]               ALU_FUN,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     ALU_OUT_VLD,
  output logic                     CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]    TX_WR_DATA,
  output logic                     TX_WR_INC,
  input  logic                     TX_FULL
);

  localparam int WORD_W = 2 * DATA_WIDTH;

  ctrl_state_e           state, state_nxt;
  logic                  wr_en_nxt, rd_en_nxt, alu_en_nxt, gate_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt;
  logic [3:0]            fun_nxt;
  logic                  push_start, push_two, push_hi_pend, push_done;
  logic [WORD_W-1:0]     push_word;

  assign push_two   = (state == ST_ALU_WAIT);
  assign push_start = (state == ST_RF_RD_WAIT && RF_RdData_VLD) ||
                      (state == ST_ALU_WAIT && ALU_OUT_VLD);
  assign push_word  = push_two ? WORD_W'(ALU_OUT)
                               : {{DATA_WIDTH{1'b0}}, RF_RdData};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= ST_IDLE;
      RF_WrEn     <= 1'b0;
      RF_RdEn     <= 1'b0;
      RF_Address  <= '0;
      RF_WrData   <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
    end else begin
      state       <= state_nxt;
      RF_WrEn     <= wr_en_nxt;
      RF_RdEn     <= rd_en_nxt;
      RF_Address  <= addr_nxt;
      RF_WrData   <= wdata_nxt;
      ALU_EN      <= alu_en_nxt;
      ALU_FUN     <= fun_nxt;
      CLK_GATE_EN <= gate_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == DATA_WIDTH'(CMD_RF_WR))          state_nxt = ST_RF_WR_ADDR;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_RF_RD))     state_nxt = ST_RF_RD_ADDR;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_W_OP))  state_nxt = ST_ALU_OPA;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_W_NOP)) state_nxt = ST_ALU_FUN;
        end
      end
      ST_RF_WR_ADDR: if (RX_D_VLD) state_nxt = ST_RF_WR_DATA;
      ST_RF_WR_DATA: if (RX_D_VLD) state_nxt = ST_IDLE;
      ST_RF_RD_ADDR: if (RX_D_VLD) state_nxt = ST_RF_RD_WAIT;
      ST_RF_RD_WAIT: if (RF_RdData_VLD) state_nxt = ST_TX_LO;
      ST_ALU_OPA:    if (RX_D_VLD) state_nxt = ST_ALU_OPB;
      ST_ALU_OPB:    if (RX_D_VLD) state_nxt = ST_ALU_FUN;
      ST_ALU_FUN:    if (RX_D_VLD) state_nxt = ST_ALU_WAIT;
      ST_ALU_WAIT:   if (ALU_OUT_VLD) state_nxt = ST_TX_LO;
      ST_TX_LO: begin
        if (push_done)         state_nxt = ST_IDLE;
        else if (push_hi_pend) state_nxt = ST_TX_HI;
      end
      ST_TX_HI:      if (push_done) state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs are computed from next state so each strobe lands
  // the cycle after the accepting edge.
  always_comb begin
    wr_en_nxt  = 1'b0;
    rd_en_nxt  = 1'b0;
    alu_en_nxt = 1'b0;
    addr_nxt   = RF_Address;
    wdata_nxt  = RF_WrData;
    fun_nxt    = ALU_FUN;
    gate_nxt   = (state_nxt == ST_ALU_FUN) || (state_nxt == ST_ALU_WAIT);
    if (RX_D_VLD) begin
      case (state)
        ST_RF_WR_ADDR: addr_nxt = RX_P_DATA[ADDR_WIDTH-1:0];
        ST_RF_WR_DATA: begin
          wr_en_nxt = 1'b1;
          wdata_nxt = RX_P_DATA;
        end
        ST_RF_RD_ADDR: begin
          rd_en_nxt = 1'b1;
          addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
        end
        ST_ALU_OPA: begin
          wr_en_nxt = 1'b1;
          addr_nxt  = ADDR_WIDTH'(RF_ADDR_OPA);
          wdata_nxt = RX_P_DATA;
        end
        ST_ALU_OPB: begin
          wr_en_nxt = 1'b1;
          addr_nxt  = ADDR_WIDTH'(RF_ADDR_OPB);
          wdata_nxt = RX_P_DATA;
        end
        ST_ALU_FUN: begin
          alu_en_nxt = 1'b1;
          fun_nxt    = RX_P_DATA[3:0];
        end
        default: ;
      endcase
    end
  end

  ctrl_tx_push #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_tx_push (
    .clk       (CLK),
    .rst_n     (RST),
    .start     (push_start),
    .two_byte  (push_two),
    .word      (push_word),
    .tx_full   (TX_FULL),
    .tx_wr_data(TX_WR_DATA),
    .tx_wr_inc (TX_WR_INC),
    .hi_pend   (push_hi_pend),
    .done      (push_done)
  );

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Scoreboard bench for sys_cmd_ctrl with 1-cycle-latency register file and
// ALU models and a controllable TX FIFO full flag.
module tb_sys_cmd_ctrl;

  logic        CLK, RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic        RF_WrEn, RF_RdEn;
  logic [3:0]  RF_Address;
  logic [7:0]  RF_WrData, RF_RdData;
  logic        RF_RdData_VLD;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic        CLK_GATE_EN;
  logic [7:0]  TX_WR_DATA;
  logic        TX_WR_INC;
  logic        TX_FULL;

  typedef struct {logic [3:0] addr; logic [7:0] data;} wr_t;
  typedef struct {logic [7:0] data; int lat;} tx_t;

  wr_t        wr_q[$];
  logic [3:0] rd_q[$];
  logic [3:0] alu_q[$];
  tx_t        tx_q[$];
  int         push_log[$];
  logic [7:0] rf_mem [16];
  logic [15:0] alu_ret;

  int   n_checks = 0, n_fail = 0;
  int   cyc = 0, last_start = 0, push_cnt = 0;
  logic full_sampled = 1'b0;

  sys_cmd_ctrl #(
    .DATA_WIDTH   (8),
    .ADDR_WIDTH   (4),
    .ALU_OUT_WIDTH(16)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_P_DATA    (RX_P_DATA),
    .RX_D_VLD     (RX_D_VLD),
    .RF_WrEn      (RF_WrEn),
    .RF_RdEn      (RF_RdEn),
    .RF_Address   (RF_Address),
    .RF_WrData    (RF_WrData),
    .RF_RdData    (RF_RdData),
    .RF_RdData_VLD(RF_RdData_VLD),
    .ALU_EN       (ALU_EN),
    .ALU_FUN      (ALU_FUN),
    .ALU_OUT      (ALU_OUT),
    .ALU_OUT_VLD  (ALU_OUT_VLD),
    .CLK_GATE_EN  (CLK_GATE_EN),
    .TX_WR_DATA   (TX_WR_DATA),
    .TX_WR_INC    (TX_WR_INC),
    .TX_FULL      (TX_FULL)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return {3'b0, RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN,
            CLK_GATE_EN, TX_WR_DATA, TX_WR_INC};
  endfunction

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
    full_sampled = TX_FULL;
  end

  // Register file / ALU models plus the output monitor.
  initial begin : mon
    logic rd_pend, alu_pend, gate_prev;
    wr_t  we;
    tx_t  te;
    logic [3:0] ea;
    rd_pend = 1'b0; alu_pend = 1'b0; gate_prev = 1'b0;
    RF_RdData = '0; RF_RdData_VLD = 1'b0; ALU_OUT = '0; ALU_OUT_VLD = 1'b0;
    forever begin
      @(negedge CLK);
      RF_RdData_VLD = rd_pend && RST;
      ALU_OUT_VLD   = alu_pend && RST;
      rd_pend  = RF_RdEn;
      alu_pend = ALU_EN;
      ALU_OUT  = alu_ret;
      if (RF_RdEn) RF_RdData = rf_mem[RF_Address];
      if (RF_WrEn) begin
        chk("wr_expected", 32'(wr_q.size() > 0), 32'd1);
        if (wr_q.size() > 0) begin
          we = wr_q.pop_front();
          chk("wr_addr", 32'(RF_Address), 32'(we.addr));
          chk("wr_data", 32'(RF_WrData), 32'(we.data));
        end
        rf_mem[RF_Address] = RF_WrData;
      end
      if (RF_RdEn) begin
        chk("rd_expected", 32'(rd_q.size() > 0), 32'd1);
        if (rd_q.size() > 0) begin
          ea = rd_q.pop_front();
          chk("rd_addr", 32'(RF_Address), 32'(ea));
        end
        last_start = cyc;
      end
      if (ALU_EN) begin
        chk("alu_expected", 32'(alu_q.size() > 0), 32'd1);
        if (alu_q.size() > 0) begin
          ea = alu_q.pop_front();
          chk("alu_fun", 32'(ALU_FUN), 32'(ea));
        end
        chk("gate_at_en", 32'(CLK_GATE_EN), 32'd1);
        chk("gate_before_en", 32'(gate_prev), 32'd1);
        last_start = cyc;
      end
      if (TX_WR_INC) begin
        push_cnt++;
        push_log.push_back(cyc);
        chk("push_when_full", 32'(full_sampled), 32'd0);
        chk("gate_at_push", 32'(CLK_GATE_EN), 32'd0);
        chk("tx_expected", 32'(tx_q.size() > 0), 32'd1);
        if (tx_q.size() > 0) begin
          te = tx_q.pop_front();
          chk("tx_data", 32'(TX_WR_DATA), 32'(te.data));
          if (te.lat >= 0) chk("tx_latency", 32'(cyc - last_start), 32'(te.lat));
        end
      end
      gate_prev = CLK_GATE_EN;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((wr_q.size() + rd_q.size() + alu_q.size() + tx_q.size()) != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_left", 32'(wr_q.size() + rd_q.size() + alu_q.size() + tx_q.size()), 32'd0);
    repeat (4) @(negedge CLK);
    chk("idle_gate", 32'(CLK_GATE_EN), 32'd0);
  endtask

  initial begin : main
    int base, fall;
    RST = 1'b0; RX_P_DATA = '0; RX_D_VLD = 1'b0; TX_FULL = 1'b0; alu_ret = '0;
    foreach (rf_mem[i]) rf_mem[i] = '0;
    #1 chk("reset_outs", outs(), 32'd0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;

    // RF write
    wr_q.push_back('{addr: 4'h5, data: 8'hD2});
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'hD2);
    drain(50);

    // RF read: one push, two cycles after RF_RdEn
    rd_q.push_back(4'h5);
    tx_q.push_back('{data: 8'hD2, lat: 2});
    send_byte(8'hBB); send_byte(8'h05);
    drain(50);

    // ALU with operands
    alu_ret = 16'h012E;
    wr_q.push_back('{addr: 4'h0, data: 8'hAD});
    wr_q.push_back('{addr: 4'h1, data: 8'h81});
    alu_q.push_back(4'h0);
    tx_q.push_back('{data: 8'h2E, lat: 2});
    tx_q.push_back('{data: 8'h01, lat: 3});
    send_byte(8'hCC); send_byte(8'hAD); send_byte(8'h81); send_byte(8'h00);
    drain(50);

    // ALU without operands
    alu_ret = 16'h572D;
    alu_q.push_back(4'h2);
    tx_q.push_back('{data: 8'h2D, lat: 2});
    tx_q.push_back('{data: 8'h57, lat: 3});
    send_byte(8'hDD); send_byte(8'h02);
    drain(50);

    // FIFO full stall during TX_LO
    @(negedge CLK);
    TX_FULL = 1'b1;
    alu_ret = 16'hBEEF;
    alu_q.push_back(4'h3);
    tx_q.push_back('{data: 8'hEF, lat: -1});
    tx_q.push_back('{data: 8'hBE, lat: -1});
    push_log.delete();
    base = push_cnt;
    send_byte(8'hDD); send_byte(8'h03);
    repeat (20) @(negedge CLK);
    chk("full_no_push", 32'(push_cnt - base), 32'd0);
    chk("full_hold_data", 32'(TX_WR_DATA), 32'hEF);
    TX_FULL = 1'b0;
    fall = cyc;
    drain(50);
    chk("full_push_count", 32'(push_log.size()), 32'd2);
    if (push_log.size() == 2) begin
      chk("full_lo_cycle", 32'(push_log[0]), 32'(fall + 1));
      chk("full_hi_cycle", 32'(push_log[1]), 32'(fall + 2));
    end

    // Junk byte, then reset after the RF_WR address byte
    send_byte(8'h55);
    send_byte(8'hAA); send_byte(8'h05);
    @(negedge CLK);
    RST = 1'b0;
    #1 chk("midrst_outs", outs(), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (5) @(negedge CLK);
    chk("midrst_outs_after", outs(), 32'd0);
    wr_q.push_back('{addr: 4'h3, data: 8'h77});
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h77);
    drain(50);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

endmodule
